// File: rtl/proc_loader_pkg.sv
// Shared types and field sizes for the boot-time program loader.
package proc_loader_pkg;

    typedef enum logic [2:0] {
        HDR_ADDR,
        HDR_CNT,
        DATA,
        WRITE,
        CHECK,
        RUN,
        ERR
    } state_t;

    localparam int HDR_ADDR_BYTES = 4;
    localparam int HDR_CNT_BYTES  = 2;
    localparam int WORD_BYTES     = 4;

endpackage

// File: rtl/proc_loader_if.sv
// Byte-stream input and external dmem write port of the loader.
interface proc_loader_if;
    logic        in_val;
    logic        in_rdy;
    logic [7:0]  in_data;
    logic        ext_dmemreq_val;
    logic        ext_dmemreq_type;
    logic [31:0] ext_dmemreq_addr;
    logic [31:0] ext_dmemreq_wdata;

    modport slave (
        input  in_val, in_data,
        output in_rdy,
        output ext_dmemreq_val, ext_dmemreq_type, ext_dmemreq_addr, ext_dmemreq_wdata
    );

    modport master (
        output in_val, in_data,
        input  in_rdy,
        input  ext_dmemreq_val, ext_dmemreq_type, ext_dmemreq_addr, ext_dmemreq_wdata
    );
endinterface

// File: rtl/proc_loader_asm.sv
// Little-endian byte assembler: each shift drops the byte into the lane
// selected by the byte index, so short fields land in the low bytes.
module proc_loader_asm
    import proc_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        shift,
    input  logic        clear,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic [1:0]  idx,
    output logic        last
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word <= '0;
            idx  <= '0;
        end else if (clear) begin
            word <= '0;
            idx  <= '0;
        end else if (shift) begin
            word[{idx, 3'b000} +: 8] <= din;
            idx                      <= idx + 2'd1;
        end
    end

    assign last = (idx == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/proc_loader.sv
// Frame parser and dmem writer; releases the processor once the frame
// checksum matches.
module proc_loader
    import proc_loader_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          restart,
    proc_loader_if.slave  bus,
    output logic          proc_go,
    output logic          done,
    output logic          err
);

    state_t             state, state_nxt;
    logic [31:0]        base;
    logic [CNT_W-1:0]   n, i, i_inc, cnt_in;
    logic [7:0]         csum;
    logic [31:0]        asm_word, addr_calc;
    logic [1:0]         asm_idx;
    logic               asm_last, asm_shift, asm_clear;
    logic               xfer, rdy_state, cnt_last, wr;
    logic [15:0]        cnt_raw;

    assign rdy_state = (state == HDR_ADDR) || (state == HDR_CNT) ||
                       (state == DATA)     || (state == CHECK);
    // Gated by rst so the stream is held off while reset is asserted.
    assign bus.in_rdy = rst & rdy_state;
    assign xfer       = bus.in_val & bus.in_rdy;

    assign cnt_last = (asm_idx == 2'(HDR_CNT_BYTES - 1));
    assign cnt_raw  = {bus.in_data, asm_word[7:0]};
    assign cnt_in   = CNT_W'(cnt_raw);
    assign i_inc    = i + CNT_W'(1);

    // Count field only fills two lanes; wipe the index before data starts.
    assign asm_shift = xfer & (state != CHECK);
    assign asm_clear = restart | (xfer & (state == HDR_CNT) & cnt_last);

    proc_loader_asm u_asm (
        .clk   (clk),
        .rst   (rst),
        .shift (asm_shift),
        .clear (asm_clear),
        .din   (bus.in_data),
        .word  (asm_word),
        .idx   (asm_idx),
        .last  (asm_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= HDR_ADDR;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (restart) begin
            state_nxt = HDR_ADDR;
        end else begin
            case (state)
                HDR_ADDR: if (xfer && asm_last)
                              state_nxt = (asm_word[1:0] != 2'b00) ? ERR : HDR_CNT;
                HDR_CNT:  if (xfer && cnt_last)
                              state_nxt = (cnt_in == '0) ? CHECK : DATA;
                DATA:     if (xfer && asm_last)
                              state_nxt = WRITE;
                WRITE:    state_nxt = (i_inc == n) ? CHECK : DATA;
                CHECK:    if (xfer)
                              state_nxt = (bus.in_data == csum) ? RUN : ERR;
                RUN:      state_nxt = RUN;
                ERR:      state_nxt = ERR;
                default:  state_nxt = HDR_ADDR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base <= '0;
            n    <= '0;
            i    <= '0;
            csum <= '0;
        end else if (restart) begin
            i    <= '0;
            csum <= '0;
        end else begin
            if (xfer && state != CHECK)
                csum <= csum + bus.in_data;
            if (xfer && state == HDR_ADDR && asm_last)
                base <= {bus.in_data, asm_word[23:0]};
            if (xfer && state == HDR_CNT && cnt_last)
                n <= cnt_in;
            if (state == WRITE)
                i <= i_inc;
        end
    end

    assign addr_calc = base + (32'(i) << 2);
    assign wr        = (state == WRITE);

    assign bus.ext_dmemreq_val   = wr;
    assign bus.ext_dmemreq_type  = wr;
    assign bus.ext_dmemreq_addr  = wr ? addr_calc : 32'd0;
    assign bus.ext_dmemreq_wdata = wr ? asm_word  : 32'd0;

    assign proc_go = (state == RUN);
    assign done    = (state == RUN);
    assign err     = (state == ERR);

endmodule

// File: tb/tb_proc_loader.sv
// Scoreboarded random/directed bench for proc_loader.
module tb_proc_loader;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic restart = 1'b0;
    logic proc_go, done, err;

    proc_loader_if bif();

    proc_loader #(.CNT_W(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .bus     (bif),
        .proc_go (proc_go),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   first_x, last_x;
    wr_t  exp_q[$];
    wr_t  mon_e;
    logic [7:0]  fq[$];
    logic [31:0] idle_v;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: every write cycle pops one expected write.
    always @(negedge clk) begin
        if (rst) begin
            if (bif.ext_dmemreq_val) begin
                chk("rdy_in_write", {31'b0, bif.in_rdy}, 32'd0);
                chk("wr_type", {31'b0, bif.ext_dmemreq_type}, 32'd1);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write actual=%h/%h required=none",
                             bif.ext_dmemreq_addr, bif.ext_dmemreq_wdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_addr", bif.ext_dmemreq_addr, mon_e.addr);
                    chk("wr_data", bif.ext_dmemreq_wdata, mon_e.data);
                end
            end else begin
                idle_v = bif.ext_dmemreq_addr | bif.ext_dmemreq_wdata |
                         {31'b0, bif.ext_dmemreq_type};
                chk("idle_bus", idle_v, 32'd0);
            end
        end
    end

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input int k);
        int t = 0;
        @(negedge clk);
        bif.in_val  = 1'b1;
        bif.in_data = b;
        while (!bif.in_rdy && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bif.in_rdy) begin
            tests++;
            fails++;
            $display("FAIL handshake_timeout actual=in_rdy0 required=in_rdy1 byte=%0d", k);
            bif.in_val = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            bif.in_val = 1'b0;
            if (k == 0) first_x = cyc;
            last_x = cyc;
        end
    endtask

    task automatic send_bytes(input int cnt, input int max_gap);
        for (int k = 0; k < cnt; k++) begin
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
            send_byte(fq[k], k);
        end
    endtask

    task automatic load_good_literal();
        fq = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00,
               8'h13, 8'h00, 8'h00, 8'h00,
               8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4E};
    endtask

    task automatic check_end(input string tag, input bit good);
        repeat (2) @(negedge clk);
        chk({tag, "_done"},   {31'b0, done},       {31'b0, good});
        chk({tag, "_go"},     {31'b0, proc_go},    {31'b0, good});
        chk({tag, "_err"},    {31'b0, err},        {31'b0, !good});
        chk({tag, "_rdy"},    {31'b0, bif.in_rdy}, 32'd0);
        chk({tag, "_pending"}, exp_q.size(),       32'd0);
        exp_q.delete();
    endtask

    task automatic do_restart(input string tag);
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk({tag, "_rdy"},  {31'b0, bif.in_rdy}, 32'd1);
        chk({tag, "_flags"}, {29'b0, done, err, proc_go}, 32'd0);
        chk({tag, "_val"},  {31'b0, bif.ext_dmemreq_val}, 32'd0);
    endtask

    // Reference model: frame bytes and expected writes straight from the
    // frame definition (LE fields, sum-mod-256 checksum).
    task automatic make_frame(input logic [31:0] base, input int n, input bit bad);
        logic [31:0] w;
        int s = 0;
        fq.delete();
        for (int b = 0; b < 4; b++) fq.push_back(8'((base >> (8 * b)) & 32'hFF));
        fq.push_back(8'(n & 255));
        fq.push_back(8'((n >> 8) & 255));
        for (int k = 0; k < n; k++) begin
            w = $urandom;
            for (int b = 0; b < 4; b++) fq.push_back(8'((w >> (8 * b)) & 32'hFF));
            if (base[1:0] == 2'b00) push_wr(base + 32'(4 * k), w);
        end
        foreach (fq[j]) s += int'(fq[j]);
        fq.push_back(8'((s + (bad ? 1 : 0)) % 256));
    endtask

    initial begin
        #3000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rb;
        int rn;
        bit rbad;
        bif.in_val  = 1'b0;
        bif.in_data = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rdy",   {31'b0, bif.in_rdy}, 32'd0);
        chk("rst_val",   {30'b0, bif.ext_dmemreq_val, bif.ext_dmemreq_type}, 32'd0);
        chk("rst_addr",  bif.ext_dmemreq_addr, 32'd0);
        chk("rst_wdata", bif.ext_dmemreq_wdata, 32'd0);
        chk("rst_flags", {29'b0, done, err, proc_go}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_rdy", {31'b0, bif.in_rdy}, 32'd1);

        // Good frame at full rate, plus frame-time check (7 + 5*2)
        push_wr(32'h100, 32'h00000013);
        push_wr(32'h104, 32'hDEADBEEF);
        load_good_literal();
        send_bytes(15, 0);
        chk("frame_time", last_x - first_x + 1, 32'd17);
        check_end("good", 1'b1);

        // Bad checksum: writes still happen, no release
        do_restart("rs1");
        push_wr(32'h100, 32'h00000013);
        push_wr(32'h104, 32'hDEADBEEF);
        load_good_literal();
        fq[14] = 8'h4F;
        send_bytes(15, 0);
        check_end("badsum", 1'b0);

        // N = 0
        do_restart("rs2");
        fq = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02};
        send_bytes(7, 0);
        check_end("n0", 1'b1);

        // Misaligned base
        do_restart("rs3");
        fq = '{8'h01, 8'h00, 8'h00, 8'h00};
        send_bytes(4, 0);
        check_end("misal", 1'b0);

        // Bubbles on the stream
        do_restart("rs4");
        push_wr(32'h100, 32'h00000013);
        push_wr(32'h104, 32'hDEADBEEF);
        load_good_literal();
        send_bytes(15, 3);
        check_end("gaps", 1'b1);

        // restart mid-DATA (one word written), then rst mid-HDR_CNT
        do_restart("rs5");
        push_wr(32'h100, 32'h00000013);
        load_good_literal();
        send_bytes(12, 0);
        do_restart("mid_data");
        chk("mid_data_pending", exp_q.size(), 32'd0);
        send_bytes(5, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_rdy",   {31'b0, bif.in_rdy}, 32'd0);
        chk("mid_rst_flags", {29'b0, done, err, proc_go}, 32'd0);
        chk("mid_rst_val",   {31'b0, bif.ext_dmemreq_val}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_rdy", {31'b0, bif.in_rdy}, 32'd1);
        push_wr(32'h100, 32'h00000013);
        push_wr(32'h104, 32'hDEADBEEF);
        load_good_literal();
        send_bytes(15, 1);
        check_end("reload", 1'b1);

        // proc_go drops as soon as rst asserts, between edges
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_go", {30'b0, proc_go, done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Randomized frames against the model
        for (int f = 0; f < 24; f++) begin
            do_restart("rsr");
            rb   = $urandom;
            rn   = $urandom_range(0, 6);
            rbad = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) begin
                if (rb[1:0] == 2'b00) rb[0] = 1'b1;
                make_frame(rb, rn, rbad);
                send_bytes(4, $urandom_range(0, 2));
                check_end("rnd_misal", 1'b0);
            end else begin
                rb[1:0] = 2'b00;
                make_frame(rb, rn, rbad);
                send_bytes(fq.size(), $urandom_range(0, 2));
                check_end("rnd", !rbad);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/proc_loader.md
# proc_loader

Boot-time program loader that sits directly upstream of the processor's external data-memory port. It consumes a framed byte stream (from the UART receiver), assembles little-endian 32-bit words and writes them into processor memory through the external dmem request interface. After a checksum-verified frame it releases the processor from reset via `proc_go`. A bad frame parks the block in an error state.

## Interface
- `CNT_W`, default 16: width of the frame word-count field and internal word counter.
- `clk` input, 1 bit: clock, rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-low (0 = reset).
- `restart` input, 1 bit: synchronous pulse; abort or finish and return to `HDR_ADDR`.
- `in_val` input, 1 bit: byte-stream valid.
- `in_rdy` output, 1 bit: byte-stream ready.
- `in_data` input, 8 bits: stream byte.
- `ext_dmemreq_val` output, 1 bit: memory request valid (single-cycle write).
- `ext_dmemreq_type` output, 1 bit: 1 = write; constant 1 whenever `val` is 1, 0 otherwise.
- `ext_dmemreq_addr` output, 32 bits: byte address, word-aligned.
- `ext_dmemreq_wdata` output, 32 bits: write data.
- `proc_go` output, 1 bit: 1 = processor out of reset. The top level drives processor `rst = ~proc_go`.
- `done` output, 1 bit: frame loaded and verified.
- `err` output, 1 bit: frame rejected.

## Operation
- Frame format, bytes in order:
  - 4-byte base address, little-endian.
  - 2-byte word count N, little-endian (`CNT_W`=16).
  - N×4 data bytes, each word little-endian.
  - 1 checksum byte equal to the sum mod 256 of every preceding frame byte.
- A byte transfers on a rising edge with `in_val && in_rdy`. The running 8-bit checksum accumulates every transferred byte except the checksum byte.
- States: `HDR_ADDR`, `HDR_CNT`, `DATA`, `WRITE`, `CHECK`, `RUN`, `ERR`.
- `HDR_ADDR`: collects 4 bytes, then goes to `HDR_CNT`. If the assembled base has bits [1:0] ≠ 0, it goes to `ERR` after the 4th byte.
- `HDR_CNT`: collects 2 bytes. If N = 0, goes to `CHECK`; otherwise goes to `DATA`.
- `DATA`: collects 4 bytes into the word assembler, then goes to `WRITE`.
- `WRITE`: one cycle with `in_rdy`=0.
  - Drives `ext_dmemreq_val`=1, `type`=1, `addr` = base + 4·i, `wdata` = assembled word.
  - Increments i.
  - If i+1 = N, goes to `CHECK`; otherwise goes to `DATA`.
- `CHECK`: accepts 1 byte. On a match, goes to `RUN`; on a mismatch, goes to `ERR`.
- `RUN`: `proc_go`=1, `done`=1, `in_rdy`=0. Stays here until `restart`.
- `ERR`: `err`=1, `proc_go`=0, `in_rdy`=0. Stays here until `restart`.
- `restart` has priority over all other transitions. It clears the byte index, word index, checksum, `proc_go`, `done` and `err`, and the next state is `HDR_ADDR`. `restart` during `WRITE` still lets that cycle's write complete.
- Address arithmetic is 32-bit and wraps modulo 2^32. No range check is made against memory size.
- Memory writes are already partial if a frame later fails the checksum. The processor is still not released in that case.

## Timing
- Reset values: `in_rdy`=0 during reset; `ext_dmemreq_val`=0, `type`=0, `addr`=0, `wdata`=0, `proc_go`=0, `done`=0, `err`=0; state `HDR_ADDR`.
- `in_rdy`=1 in `HDR_ADDR`, `HDR_CNT`, `DATA` and `CHECK`.
- Memory outputs are registered-state decodes. They are valid in the `WRITE` cycle and are 0 in all other cycles.
- The 4th data byte is accepted at edge k. The write is presented during cycle k..k+1 and committed at edge k+1. The next byte is accepted no earlier than edge k+2.
- Minimum frame time is 7 + 5N cycles at full stream rate.
- `proc_go` rises on the edge that accepts a correct checksum byte. It falls on the edge that samples `restart`, or immediately on assertion of `rst`.
- Asynchronous reset mid-frame discards all progress. Memory contents are untouched.

## Structure
- `proc_loader_pkg`: state enum; constants `HDR_ADDR_BYTES`=4, `HDR_CNT_BYTES`=2, `WORD_BYTES`=4.
- Sub-module `proc_loader_asm`: 32-bit little-endian byte shifter with a 2-bit byte index.
  - Inputs: `shift`, `clear`, byte.
  - Outputs: `word`, `last` (index = 3).
  - Reused for the address, count and data fields.
- The top level holds the FSM, base register, word counter i (`CNT_W` bits) and checksum accumulator.

## Test plan
- Good frame `00 01 00 00 02 00 13 00 00 00 EF BE AD DE 4E` →
  - writes (0x100, 0x00000013) then (0x104, 0xDEADBEEF), each exactly one `val` cycle;
  - `proc_go`=`done`=1 after the last byte.
- Same frame with checksum `4F` → both writes occur; `err`=1; `proc_go` stays 0.
- N=0 frame `00 02 00 00 00 00 02` → no writes; `done`=1.
- Misaligned base `01 00 00 00` → `err`=1 after the 4th byte; no writes; `in_rdy`=0.
- Backpressure and bubbles: random `in_val` gaps → same writes as the good-frame case; `in_rdy` is 0 in every `WRITE` cycle.
- `restart` mid-`DATA`, then `rst` low mid-`HDR_CNT` → state returns to `HDR_ADDR`; all outputs are 0; a following good frame loads correctly.
